key_debounce: RTL and testbench

- Debounces the elevator's raw push-buttons: floor calls, door open/close and emergency.
- Sits directly downstream of the clock divider and consumes its 50 Hz output as a sampling strobe.
- Runs entirely in the clk_in domain; the divided clock is never used as a clock edge.
- Outputs clean key levels plus single-cycle press/release pulses for the elevator controller FSM.

---
 rtl/key_debounce_pkg.sv | 10 +
 rtl/key_debounce_cell.sv | 96 +++++++++
 rtl/key_debounce.sv | 52 +++++
 tb/tb_key_debounce.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state type, counter width helper and default constants
package key_debounce_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} key_state_t;
  localparam int STABLE_SAMPLES_DEF = 3;
  localparam int REPEAT_DELAY_DEF = 25;
  localparam int REPEAT_PERIOD_DEF = 5;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: one key's synchronizer, debounce FSM and pulse outputs (auto-repeat under KEY_DEBOUNCE_REPEAT_EN)
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int RAW_ACTIVE_LOW = 1
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic strobe_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o
);
  localparam int CW = cnt_w(STABLE_SAMPLES);
  localparam logic [CW-1:0] SS = CW'(STABLE_SAMPLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [1:0] sync_q;
  key_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, inc;
  logic level_q, press_q, rel_q, level_d, press_d, rel_d, sample, hit, rise, rep;
  assign sample = (RAW_ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
  assign inc = cnt_q + ONE;
  assign hit = (inc == SS);
  // next state and counter, evaluated only on strobe cycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (strobe_i)
      case (state_q)
        RELEASED: if (sample) begin
          state_d = (SS == ONE) ? PRESSED : PRESS_PEND;
          cnt_d = (SS == ONE) ? '0 : ONE;
        end
        PRESS_PEND: begin
          state_d = !sample ? RELEASED : (hit ? PRESSED : PRESS_PEND);
          cnt_d = (!sample || hit) ? '0 : inc;
        end
        PRESSED: if (!sample) begin
          state_d = (SS == ONE) ? RELEASED : RELEASE_PEND;
          cnt_d = (SS == ONE) ? '0 : ONE;
        end
        default: begin
          state_d = sample ? PRESSED : (hit ? RELEASED : RELEASE_PEND);
          cnt_d = (sample || hit) ? '0 : inc;
        end
      endcase
  end
  assign level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
  assign rise = level_d & ~level_q;
  assign press_d = rise | rep;
  assign rel_d = level_q & ~level_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int HW = cnt_w(REPEAT_DELAY);
  localparam logic [HW-1:0] HD = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HR = HW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic stay;
  assign hold_inc = hold_q + HW'(1);
  assign stay = strobe_i && (state_q == PRESSED) && (state_d == PRESSED);
  assign rep = stay && (hold_inc == HD);
  assign hold_d = (state_d == RELEASED || rise) ? '0 : stay ? (rep ? HR : hold_inc) : hold_q;
  // hold counter: reloads after each repeat so the next one follows REPEAT_PERIOD later
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) hold_q <= '0;
    else hold_q <= hold_d;
`else
  assign rep = 1'b0;
`endif
  // synchronizer, FSM state and registered outputs
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= RELEASED;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
    end
  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o = rel_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: 50 Hz strobe generator plus NUM_KEYS debounce cells (auto-repeat under KEY_DEBOUNCE_REPEAT_EN)
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int RAW_ACTIVE_LOW = 1
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                sample_clk_in,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  logic [2:0] samp_q;
  logic strobe_q;
  // synchronize the divider output and register its rising edge as a one-cycle strobe
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      samp_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      samp_q <= {samp_q[1:0], sample_clk_in};
      strobe_q <= samp_q[1] & ~samp_q[2];
    end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .RAW_ACTIVE_LOW(RAW_ACTIVE_LOW)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .strobe_i(strobe_q),
      .raw_i   (key_raw[i]),
      .level_o (key_level[i]),
      .press_o (key_press[i]),
      .rel_o   (key_release[i])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized scoreboard bench against a run-length debounce model
module tb_key_debounce;
  localparam int N = 8;
  localparam int SS = 3;
  localparam int RD = 25;
  localparam int RP = 5;
  typedef struct {int t; logic [N-1:0] lv; logic [N-1:0] pr; logic [N-1:0] rl;} exp_t;
  logic clk_in = 0, rst_n = 0, sample_clk_in = 0;
  logic [N-1:0] key_raw = '1;
  logic [N-1:0] key_level, key_press, key_release;
  logic [N-1:0] lvl = '0, cur = '0;
  int run[N], hold[N];
  int cyc = 0, tests = 0, fails = 0;
  exp_t q[$];
  exp_t me;

  key_debounce #(.NUM_KEYS(N), .STABLE_SAMPLES(SS), .RAW_ACTIVE_LOW(1)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sample_clk_in(sample_clk_in), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic clear_model();
    lvl = '0;
    for (int k = 0; k < N; k++) begin
      run[k] = 0;
      hold[k] = 0;
    end
    q.delete();
  endtask

  // a level flips after SS consecutive samples disagreeing with it; outputs show 4 cycles after the sample edge
  task automatic model(input logic [N-1:0] s);
    exp_t e;
    e.pr = '0;
    e.rl = '0;
    for (int k = 0; k < N; k++) begin
      if (s[k] != lvl[k]) begin
        run[k]++;
        if (run[k] == SS) begin
          lvl[k] = s[k];
          run[k] = 0;
          hold[k] = 0;
          if (s[k]) e.pr[k] = 1'b1;
          else e.rl[k] = 1'b1;
        end
      end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
        if (lvl[k] && run[k] == 0) begin
          hold[k]++;
          if (hold[k] >= RD && (hold[k] - RD) % RP == 0) e.pr[k] = 1'b1;
        end
`endif
        run[k] = 0;
      end
    end
    e.lv = lvl;
    e.t = cyc + 4;
    q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] m);
    key_raw = ~m;
    repeat (10) @(posedge clk_in);
    #1 sample_clk_in = 1;
    model(m);
    repeat (10) @(posedge clk_in);
    #1 sample_clk_in = 0;
  endtask

  task automatic steps(input logic [N-1:0] m, input int n);
    for (int i = 0; i < n; i++) step(m);
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if (key_level !== '0 || key_press !== '0 || key_release !== '0) begin
      fails++;
      $display("FAIL %s level=%h press=%h release=%h required all 0", nm, key_level, key_press, key_release);
    end
  endtask

  // monitor: compares scheduled strobe responses and flags any unscheduled pulse
  always @(negedge clk_in)
    if (rst_n) begin
      if (q.size() != 0 && q[0].t == cyc) begin
        me = q.pop_front();
        tests++;
        if (key_press !== me.pr || key_release !== me.rl || key_level !== me.lv) begin
          fails++;
          $display("FAIL strobe_out cyc=%0d press=%h/%h release=%h/%h level=%h/%h (actual/required)",
                   cyc, key_press, me.pr, key_release, me.rl, key_level, me.lv);
        end
      end else if ((key_press | key_release) != '0) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse cyc=%0d press=%h release=%h required 0", cyc, key_press, key_release);
      end
    end

  initial begin
    clear_model();
    repeat (3) @(posedge clk_in);
    #1 check_zero("reset_state");
    rst_n = 1;
    steps(cur, 2);
    cur[0] = 1'b1;
    steps(cur, 5);
    step(cur | 8'h02);
    steps(cur, 2);
    step(cur | 8'h02);
    steps(cur, 2);
    cur[2] = 1'b1;
    steps(cur, 4);
    cur[2] = 1'b0;
    steps(cur, 4);
    cur = cur | 8'h28;
    steps(cur, 4);
    cur = 8'h01;
    steps(cur, 4);
    cur[4] = 1'b1;
    steps(cur, 2);
    #1 rst_n = 0;
    #1 check_zero("reset_async");
    clear_model();
    repeat (3) @(posedge clk_in);
    #1 check_zero("reset_held");
    rst_n = 1;
    steps(cur, 4);
    cur = 8'h01;
    steps(cur, 42);
    cur = '0;
    steps(cur, 4);
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) cur[k] = ~cur[k];
      step(cur);
    end
    repeat (20) @(posedge clk_in);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
